lcd_msg_sequencer: RTL and testbench

LCD_MSG_SEQUENCER -- requirements
Module: lcd_msg_sequencer

---
 rtl/lcd_msg_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_msg_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_msg_sequencer.sv
// HD44780 message sequencer: power-up wait, init bytes, then redraws one of NUM_MSG stored messages on request.
// Define LCD_TWO_LINE_EN for a 2x16 display (32 chars per message, 0xC0 between the two halves).
module lcd_msg_sequencer #(
  parameter int NUM_MSG = 8,
  parameter int T_EN    = 25,
  parameter int T_CMD   = 2500,
  parameter int T_CLR   = 100000,
  parameter int T_PWR   = 2000000,
  localparam int CMD_W  = (NUM_MSG > 2) ? $clog2(NUM_MSG) : 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             done,
  output logic             err,
  output logic [CMD_W+4:0] rom_addr,
  input  logic [7:0]       rom_char,
  output logic [7:0]       lcd_data,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic             lcd_en
);

  localparam int T_MAX_A = (T_PWR > T_CLR) ? T_PWR : T_CLR;
  localparam int T_MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CNT_W   = $clog2(T_MAX + 1);
  localparam logic [CMD_W:0] MSG_LIMIT = (CMD_W+1)'(NUM_MSG);

`ifdef LCD_TWO_LINE_EN
  localparam logic [7:0] FUNC_SET = 8'h38;
`else
  localparam logic [7:0] FUNC_SET = 8'h30;
`endif

  typedef enum logic [2:0] {
    S_PWR_WAIT, S_INIT, S_IDLE, S_CLEAR, S_HOME, S_CHARS, S_LINE2, S_CHARS2
  } state_t;

  typedef enum logic [1:0] {P_SETUP, P_EN, P_WAIT} phase_t;

  state_t           state, state_n;
  phase_t           phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       init_idx, init_idx_n;
  logic [4:0]       char_idx, char_idx_n;
  logic [7:0]       data_q, data_n;
  logic             rs_n;
  logic [CMD_W-1:0] cmd_q, cmd_q_n, last_idx, last_idx_n;
  logic             last_valid, last_valid_n;
  logic             done_n, err_n;
  logic             slot_end, finish, is_char, cmd_oob;

  assign is_char  = (state == S_CHARS) || (state == S_CHARS2);
  assign cmd_oob  = ({1'b0, cmd} >= MSG_LIMIT);
  assign rom_addr = {cmd_q, char_idx};
  assign lcd_rw   = 1'b0;
  // The ROM is combinational, so the char is shown directly during setup and held in data_q afterwards.
  assign lcd_data = (is_char && phase == P_SETUP) ? rom_char : data_q;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state      <= S_PWR_WAIT;
      phase      <= P_SETUP;
      cnt        <= CNT_W'(T_PWR - 1);
      init_idx   <= '0;
      char_idx   <= '0;
      data_q     <= '0;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      cmd_ready  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cmd_q      <= '0;
      last_idx   <= '0;
      last_valid <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      cnt        <= cnt_n;
      init_idx   <= init_idx_n;
      char_idx   <= char_idx_n;
      data_q     <= data_n;
      lcd_rs     <= rs_n;
      lcd_en     <= (phase_n == P_EN);
      cmd_ready  <= (state_n == S_IDLE);
      done       <= done_n;
      err        <= err_n;
      cmd_q      <= cmd_q_n;
      last_idx   <= last_idx_n;
      last_valid <= last_valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    cnt_n        = cnt;
    init_idx_n   = init_idx;
    char_idx_n   = char_idx;
    data_n       = data_q;
    rs_n         = lcd_rs;
    cmd_q_n      = cmd_q;
    last_idx_n   = last_idx;
    last_valid_n = last_valid;
    done_n       = 1'b0;
    err_n        = 1'b0;
    slot_end     = 1'b0;
    finish       = 1'b0;

    case (state)
      S_PWR_WAIT: begin
        if (cnt == '0) begin
          state_n    = S_INIT;
          phase_n    = P_SETUP;
          data_n     = FUNC_SET;
          rs_n       = 1'b0;
          init_idx_n = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_q_n = cmd;
          if (cmd_oob) begin
            err_n  = 1'b1;
            done_n = 1'b1;
          end else if (last_valid && cmd == last_idx) begin
            done_n = 1'b1;
          end else begin
            state_n    = S_CLEAR;
            phase_n    = P_SETUP;
            data_n     = 8'h01;
            rs_n       = 1'b0;
            char_idx_n = '0;
          end
        end
      end
      default: begin
        case (phase)
          P_SETUP: begin
            phase_n = P_EN;
            cnt_n   = CNT_W'(T_EN - 1);
            if (is_char) data_n = rom_char;
          end
          P_EN: begin
            if (cnt == '0) begin
              phase_n = P_WAIT;
              cnt_n   = (!lcd_rs && data_q == 8'h01) ? CNT_W'(T_CLR - 1) : CNT_W'(T_CMD - 1);
            end else begin
              cnt_n = cnt - 1'b1;
            end
          end
          P_WAIT: begin
            if (cnt == '0) slot_end = 1'b1;
            else           cnt_n = cnt - 1'b1;
          end
          default: phase_n = P_SETUP;
        endcase
      end
    endcase

    if (slot_end) begin
      phase_n = P_SETUP;
      case (state)
        S_INIT: begin
          init_idx_n = init_idx + 1'b1;
          case (init_idx)
            2'd0:    data_n  = 8'h0C;
            2'd1:    data_n  = 8'h06;
            2'd2:    data_n  = 8'h01;
            default: state_n = S_IDLE;
          endcase
        end
        S_CLEAR: begin
          state_n = S_HOME;
          data_n  = 8'h80;
        end
        S_HOME: begin
          state_n    = S_CHARS;
          rs_n       = 1'b1;
          char_idx_n = '0;
        end
        S_CHARS: begin
          char_idx_n = char_idx + 1'b1;
          if (char_idx == 5'd15) begin
`ifdef LCD_TWO_LINE_EN
            state_n = S_LINE2;
            data_n  = 8'hC0;
            rs_n    = 1'b0;
`else
            finish  = 1'b1;
`endif
          end
        end
        S_LINE2: begin
          state_n = S_CHARS2;
          rs_n    = 1'b1;
        end
        S_CHARS2: begin
          char_idx_n = char_idx + 1'b1;
          if (char_idx == 5'd31) finish = 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end

    if (finish) begin
      state_n      = S_IDLE;
      done_n       = 1'b1;
      last_idx_n   = cmd_q;
      last_valid_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Directed bench for lcd_msg_sequencer: init sequence, redraw, suppression, error, busy handshake, reset abort.
module tb_lcd_msg_sequencer;

  localparam int NUM_MSG = 5;
  localparam int T_EN    = 2;
  localparam int T_CMD   = 4;
  localparam int T_CLR   = 10;
  localparam int T_PWR   = 20;
  localparam int CMD_W   = 3;
`ifdef LCD_TWO_LINE_EN
  localparam int         NCH  = 32;
  localparam logic [7:0] FSET = 8'h38;
  localparam int         LAT  = 252;
`else
  localparam int         NCH  = 16;
  localparam logic [7:0] FSET = 8'h30;
  localparam int         LAT  = 133;
`endif
  localparam int INIT_SPAN = 3 * (1 + T_EN + T_CMD) + (1 + T_EN + T_CLR) - 1;

  logic             clk = 1'b0;
  logic             rstb;
  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic             cmd_ready, done, err;
  logic [CMD_W+4:0] rom_addr;
  logic [7:0]       rom_char;
  logic [7:0]       lcd_data;
  logic             lcd_rs, lcd_rw, lcd_en;

  lcd_msg_sequencer #(
    .NUM_MSG(NUM_MSG), .T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR), .T_PWR(T_PWR)
  ) dut (
    .clk(clk), .rstb(rstb), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .done(done), .err(err), .rom_addr(rom_addr), .rom_char(rom_char),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
  );

  always #5 clk = ~clk;

  assign rom_char = rom_addr ^ 8'hA5;

  function automatic logic [7:0] chr(int m, int i);
    logic [7:0] a;
    a = {m[2:0], i[4:0]};
    return a ^ 8'hA5;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte capture on every lcd_en rising edge, plus pulse-width and data-hold checks.
  logic [8:0] bytes[$];
  logic       en_prev = 1'b0;
  logic [8:0] prev_val = '0;
  logic [8:0] hi_val = '0;
  int         hi_len = 0;

  always @(negedge clk) begin
    if (rstb === 1'b1 && lcd_en && !en_prev) begin
      check("setup_hold", {lcd_rs, lcd_data}, prev_val);
      bytes.push_back({lcd_rs, lcd_data});
      hi_val = {lcd_rs, lcd_data};
      hi_len = 1;
    end else if (lcd_en) begin
      hi_len++;
    end
    if (rstb === 1'b1 && !lcd_en && en_prev) begin
      check("en_width", hi_len, T_EN);
      check("data_hold", {lcd_rs, lcd_data}, hi_val);
    end
    en_prev  = lcd_en;
    prev_val = {lcd_rs, lcd_data};
  end

  task automatic check_reset_outs(string tag);
    check(tag, {lcd_data, lcd_rs, lcd_rw, lcd_en, cmd_ready, done, err, rom_addr}, 0);
  endtask

  task automatic wait_ready(int budget);
    for (int i = 0; i < budget; i++) begin
      if (cmd_ready) return;
      @(negedge clk);
    end
    check("ready_timeout", 0, 1);
  endtask

  task automatic send(logic [CMD_W-1:0] c, output int hs);
    cmd       = c;
    cmd_valid = 1'b1;
    hs        = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(int budget, output int dc, output int busy_hi);
    busy_hi = 0;
    dc      = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        dc = cyc;
        return;
      end
      if (cmd_ready) busy_hi++;
      @(negedge clk);
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic check_seq(int m);
    logic [8:0] exp[$];
    exp.push_back({1'b0, 8'h01});
    exp.push_back({1'b0, 8'h80});
    for (int i = 0; i < NCH; i++) begin
      if (i == 16) exp.push_back({1'b0, 8'hC0});
      exp.push_back({1'b1, chr(m, i)});
    end
    check("seq_len", bytes.size(), exp.size());
    for (int i = 0; i < exp.size() && i < bytes.size(); i++)
      check($sformatf("seq_m%0d_b%0d", m, i), bytes[i], exp[i]);
  endtask

  task automatic init_seq(string tag);
    int n, first;
    bytes.delete();
    rstb = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lcd_en) break;
      n++;
    end
    check({tag, "_pwr"}, n, T_PWR);
    first = cyc;
    wait_ready(200);
    check({tag, "_span"}, cyc - first, INIT_SPAN);
    check({tag, "_len"}, bytes.size(), 4);
    if (bytes.size() == 4) begin
      check({tag, "_b0"}, bytes[0], {1'b0, FSET});
      check({tag, "_b1"}, bytes[1], {1'b0, 8'h0C});
      check({tag, "_b2"}, bytes[2], {1'b0, 8'h06});
      check({tag, "_b3"}, bytes[3], {1'b0, 8'h01});
    end
  endtask

  task automatic redraw(int m);
    int hs, dc, bh;
    wait_ready(400);
    bytes.delete();
    send(m[CMD_W-1:0], hs);
    wait_done(400, dc, bh);
    check("redraw_lat", dc - hs, LAT);
    check("redraw_busy", bh, 0);
    check("redraw_err", err, 0);
    check("redraw_ready", cmd_ready, 1);
    check_seq(m);
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask

  task automatic no_redraw(int m, logic exp_err, string tag);
    int hs, n0;
    wait_ready(400);
    n0 = bytes.size();
    send(m[CMD_W-1:0], hs);
    check({tag, "_done"}, done, 1);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_t"}, cyc - hs, 1);
    repeat (10) @(negedge clk);
    check({tag, "_quiet"}, bytes.size(), n0);
    check({tag, "_idle"}, {done, err}, 0);
  endtask

  initial begin
    int hs, dc, bh;
    rstb      = 1'b0;
    cmd       = '0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset_outs");

    init_seq("init");
    redraw(2);
    no_redraw(2, 1'b0, "same");
    no_redraw(6, 1'b1, "oob");
    no_redraw(2, 1'b0, "same_after_oob");

    // cmd_valid held across a whole redraw; the changed cmd is taken in the done cycle.
    wait_ready(400);
    bytes.delete();
    cmd       = 3'd3;
    cmd_valid = 1'b1;
    hs        = cyc;
    @(negedge clk);
    cmd = 3'd4;
    wait_done(400, dc, bh);
    check("hold_lat", dc - hs, LAT);
    check("hold_busy", bh, 0);
    check("hold_ready_at_done", cmd_ready, 1);
    check_seq(3);
    bytes.delete();
    hs = dc;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("hold_accept", {cmd_ready, done}, 0);
    wait_done(400, dc, bh);
    check("hold2_lat", dc - hs, LAT);
    check_seq(4);

    // Abort a redraw while the 5th char is strobing.
    wait_ready(400);
    bytes.delete();
    send(3'd1, hs);
    for (int i = 0; i < 300; i++) begin
      if (bytes.size() >= 7) break;
      @(negedge clk);
    end
    check("abort_reach", (bytes.size() >= 7) ? 1 : 0, 1);
    check("abort_en_high", lcd_en, 1);
    rstb = 1'b0;
    @(negedge clk);
    check_reset_outs("abort_outs");
    @(negedge clk);
    init_seq("reinit");
    redraw(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
